pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipelined RISC-V core. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and drives their enable and flush controls. It resolves load-use hazards, EX-stage control-flow redirects and multi-cycle data-memory waits with a fixed priority. It also supervises the memory handshake with a timeout and keeps saturating performance counters.

---
 rtl/pipeline_ctrl_if.sv | 40 ++++
 rtl/pipeline_ctrl.sv | 111 +++++++++++
 tb/tb_pipeline_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and pipeline-register controls exchanged with the stall/flush sequencer.
// master = datapath side, slave = pipeline_ctrl.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             ex_memread;
  logic [4:0]       ex_rd;
  logic             ex_redirect;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_wb_bubble;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] redirect_count;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_memread, ex_rd,
           ex_redirect, dmem_req, dmem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush,
           id_ex_flush, mem_wb_bubble, mem_err, stall_cycles, redirect_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_memread, ex_rd,
           ex_redirect, dmem_req, dmem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush,
           id_ex_flush, mem_wb_bubble, mem_err, stall_cycles, redirect_count
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage core: freeze > redirect > load-use > run,
// with a data-memory wait timeout and saturating performance counters.
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic           clk,
  input  logic           rst,
  pipeline_ctrl_if.slave bus
);
  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  state_t           state;
  logic [WCW-1:0]   wait_cnt;
  logic             err_q;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] redir_q;

  logic freeze, load_use, redirect_ok;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, mem_wb_bubble;

  always_comb begin
    freeze = (state == RUN && bus.dmem_req && !bus.dmem_ready) ||
             (state == MEM_WAIT && !bus.dmem_ready) ||
             (state == ERR);
    load_use = bus.ex_memread && (bus.ex_rd != 5'd0) &&
               ((bus.id_uses_rs1 && bus.id_rs1 == bus.ex_rd) ||
                (bus.id_uses_rs2 && bus.id_rs2 == bus.ex_rd));
    redirect_ok = !rst && !freeze && bus.ex_redirect;
  end

  always_comb begin
    pc_en         = 1'b0;
    if_id_en      = 1'b0;
    id_ex_en      = 1'b0;
    ex_mem_en     = 1'b0;
    mem_wb_en     = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    if (!rst) begin
      if (freeze) begin
        mem_wb_bubble = 1'b1;
      end else if (bus.ex_redirect) begin
        // the squashed ID instruction makes any concurrent load-use hazard moot
        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
      end else begin
        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      err_q    <= 1'b0;
      stall_q  <= '0;
      redir_q  <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (bus.dmem_req && !bus.dmem_ready) begin
            state    <= MEM_WAIT;
            wait_cnt <= WCW'(1);
          end
        end
        MEM_WAIT: begin
          // dmem_req is not re-examined here; the frozen EX/MEM register holds the access
          if (bus.dmem_ready) begin
            state <= RUN;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= ERR;
            err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        default: begin
          state <= ERR;
          err_q <= 1'b1;
        end
      endcase
      if (!pc_en && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
      if (redirect_ok && redir_q != '1) redir_q <= redir_q + CNT_W'(1);
    end
  end

  assign bus.pc_en          = pc_en;
  assign bus.if_id_en       = if_id_en;
  assign bus.id_ex_en       = id_ex_en;
  assign bus.ex_mem_en      = ex_mem_en;
  assign bus.mem_wb_en      = mem_wb_en;
  assign bus.if_id_flush    = if_id_flush;
  assign bus.id_ex_flush    = id_ex_flush;
  assign bus.mem_wb_bubble  = mem_wb_bubble;
  assign bus.mem_err        = err_q && !rst;
  assign bus.stall_cycles   = stall_q;
  assign bus.redirect_count = redir_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with MEM_TIMEOUT=4 and CNT_W=4.
module tb_pipeline_ctrl;
  localparam int TO = 4;
  localparam int CW = 4;

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_wb_bubble}
  localparam logic [7:0] C_DEF = 8'b11111_000;
  localparam logic [7:0] C_FRZ = 8'b00000_001;
  localparam logic [7:0] C_RED = 8'b11111_110;
  localparam logic [7:0] C_LU  = 8'b00111_010;
  localparam logic [7:0] C_RST = 8'b00000_000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;

  pipeline_ctrl_if #(.CNT_W(CW)) bus ();
  pipeline_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [7:0] ctrl;
  assign ctrl = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
                 bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_bubble};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // advance one clock edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0;
    bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0;
    bus.ex_memread = 1'b0; bus.ex_rd = 5'd0;
    bus.ex_redirect = 1'b0; bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #1;
    check("rst_ctrl", 32'(ctrl), 32'(C_RST));
    check("rst_err", 32'(bus.mem_err), 32'd0);
    tick();
    check("rst_stall", 32'(bus.stall_cycles), 32'd0);
    check("rst_redir", 32'(bus.redirect_count), 32'd0);
    rst = 1'b0;
    #1;
    check("run_default", 32'(ctrl), 32'(C_DEF));

    // load-use through rs1
    bus.ex_memread = 1'b1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5; bus.id_uses_rs1 = 1'b1;
    #1;
    check("lu_rs1", 32'(ctrl), 32'(C_LU));
    tick();
    bus.ex_memread = 1'b0;
    #1;
    check("lu_after", 32'(ctrl), 32'(C_DEF));
    check("lu_stall1", 32'(bus.stall_cycles), 32'd1);

    // x0 destination never hazards
    bus.ex_memread = 1'b1; bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0;
    #1;
    check("lu_x0", 32'(ctrl), 32'(C_DEF));
    tick();
    check("lu_x0_stall", 32'(bus.stall_cycles), 32'd1);

    // load-use through rs2; rs1 match without use flag must not matter
    bus.ex_rd = 5'd9; bus.id_rs1 = 5'd9; bus.id_uses_rs1 = 1'b0;
    #1;
    check("lu_rs1_unused", 32'(ctrl), 32'(C_DEF));
    bus.id_rs2 = 5'd9; bus.id_uses_rs2 = 1'b1;
    #1;
    check("lu_rs2", 32'(ctrl), 32'(C_LU));
    tick();
    check("lu_rs2_stall", 32'(bus.stall_cycles), 32'd2);

    // redirect with concurrent load-use
    do_reset();
    bus.ex_memread = 1'b1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5; bus.id_uses_rs1 = 1'b1;
    bus.ex_redirect = 1'b1;
    #1;
    check("redir_lu", 32'(ctrl), 32'(C_RED));
    tick();
    idle_inputs();
    #1;
    check("redir_count", 32'(bus.redirect_count), 32'd1);
    check("redir_stall", 32'(bus.stall_cycles), 32'd0);
    check("redir_after", 32'(ctrl), 32'(C_DEF));

    // memory wait: ready on the 4th request cycle
    do_reset();
    bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("mw_frozen", 32'(ctrl), 32'(C_FRZ));
      tick();
    end
    bus.dmem_ready = 1'b1;
    #1;
    check("mw_release", 32'(ctrl), 32'(C_DEF));
    tick();
    check("mw_stall", 32'(bus.stall_cycles), 32'd3);
    bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0;
    #1;
    check("mw_back_run", 32'(ctrl), 32'(C_DEF));

    // timeout after MEM_TIMEOUT unready cycles
    do_reset();
    bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0;
    for (int i = 0; i < TO - 1; i++) tick();
    check("to_not_yet", 32'(bus.mem_err), 32'd0);
    tick();
    check("to_err", 32'(bus.mem_err), 32'd1);
    bus.dmem_ready = 1'b1;
    #1;
    check("to_frozen_ready", 32'(ctrl), 32'(C_FRZ));
    tick();
    check("to_err_sticky", 32'(bus.mem_err), 32'd1);
    check("to_stall", 32'(bus.stall_cycles), 32'd5);
    rst = 1'b1;
    #1;
    check("to_rst_ctrl", 32'(ctrl), 32'(C_RST));
    check("to_rst_err", 32'(bus.mem_err), 32'd0);
    tick();
    rst = 1'b0;
    idle_inputs();
    #1;
    check("to_run_after", 32'(ctrl), 32'(C_DEF));
    check("to_cnt_clr", 32'(bus.stall_cycles), 32'd0);
    check("to_err_clr", 32'(bus.mem_err), 32'd0);

    // redirect held through a freeze
    do_reset();
    bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0; bus.ex_redirect = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("rf_frozen", 32'(ctrl), 32'(C_FRZ));
      tick();
    end
    check("rf_cnt0", 32'(bus.redirect_count), 32'd0);
    bus.dmem_ready = 1'b1;
    #1;
    check("rf_release", 32'(ctrl), 32'(C_RED));
    tick();
    idle_inputs();
    #1;
    check("rf_cnt1", 32'(bus.redirect_count), 32'd1);
    check("rf_after", 32'(ctrl), 32'(C_DEF));

    // stall counter saturation
    do_reset();
    bus.ex_memread = 1'b1; bus.ex_rd = 5'd7; bus.id_rs2 = 5'd7; bus.id_uses_rs2 = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    check("sat_15", 32'(bus.stall_cycles), 32'd15);
    for (int i = 0; i < 5; i++) tick();
    check("sat_20", 32'(bus.stall_cycles), 32'd15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
